// File: rtl/maxnet_input_loader.sv
// Input loader for the 4-neuron MaxNet datapath: assembles a serial word stream
// into the W and X banks, then pulses start and waits for the datapath result.
module maxnet_input_loader #(
   parameter int WIDTH = 32,
   parameter int N     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_type,
   input  logic                 done_in,
   output logic [N*WIDTH-1:0]   x_flat,
   output logic [N*N*WIDTH-1:0] w_flat,
   output logic                 w_loaded,
   output logic                 start,
   output logic                 busy,
   output logic                 err_no_w
);
   localparam int CW = $clog2(N*N);
   localparam int XW = $clog2(N);
   localparam logic [CW-1:0] W_LAST = CW'(N*N-1);
   localparam logic [CW-1:0] X_LAST = CW'(N-1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_W = 3'd1,
      ST_LOAD_X = 3'd2,
      ST_START  = 3'd3,
      ST_WAIT   = 3'd4
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic [CW-1:0]    cnt_r;
   logic [CW-1:0]    cnt_next_s;
   logic [WIDTH-1:0] w_bank_r [N*N];
   logic [WIDTH-1:0] x_bank_r [N];
   logic             w_loaded_r;
   logic             err_no_w_r;
   logic             in_ready_r;
   logic             busy_r;
   logic             start_r;
   logic             ready_next_s;
   logic             busy_next_s;
   logic             start_next_s;
   logic             accept_s;
   logic             wr_w_s;
   logic             wr_x_s;
   logic             set_wl_s;
   logic             set_err_s;

   // in_ready is a registered state decode, so acceptance never depends
   // combinationally on in_valid.
   assign accept_s = in_valid & in_ready_r;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && in_type) begin
               state_next_s = ST_LOAD_W;
            end else if (accept_s && w_loaded_r) begin
               state_next_s = ST_LOAD_X;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_LOAD_W: begin
            if (accept_s && (cnt_r == W_LAST)) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_LOAD_W;
            end
         end
         ST_LOAD_X: begin
            if (accept_s && (cnt_r == X_LAST)) begin
               state_next_s = ST_START;
            end else begin
               state_next_s = ST_LOAD_X;
            end
         end
         // done_in in the START cycle still reflects the previous result
         ST_START: state_next_s = ST_WAIT;
         ST_WAIT: begin
            if (done_in) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state, so every output is a flop
   always_comb begin
      ready_next_s = 1'b0;
      busy_next_s  = 1'b0;
      start_next_s = 1'b0;
      case (state_next_s)
         ST_IDLE, ST_LOAD_W, ST_LOAD_X: ready_next_s = 1'b1;
         ST_START: begin
            busy_next_s  = 1'b1;
            start_next_s = 1'b1;
         end
         ST_WAIT: busy_next_s = 1'b1;
         default: ready_next_s = 1'b0;
      endcase
   end

   // Output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready_r <= 1'b1;
         busy_r     <= 1'b0;
         start_r    <= 1'b0;
      end else begin
         in_ready_r <= ready_next_s;
         busy_r     <= busy_next_s;
         start_r    <= start_next_s;
      end
   end

   // Beat steering: the counter is zero in IDLE, so it is always the write index
   always_comb begin
      wr_w_s     = 1'b0;
      wr_x_s     = 1'b0;
      set_wl_s   = 1'b0;
      set_err_s  = 1'b0;
      cnt_next_s = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && in_type) begin
               wr_w_s     = 1'b1;
               cnt_next_s = CW'(1'b1);
            end else if (accept_s && w_loaded_r) begin
               wr_x_s     = 1'b1;
               cnt_next_s = CW'(1'b1);
            end else if (accept_s) begin
               set_err_s  = 1'b1;
               cnt_next_s = '0;
            end else begin
               cnt_next_s = '0;
            end
         end
         ST_LOAD_W: begin
            if (accept_s && (cnt_r == W_LAST)) begin
               wr_w_s     = 1'b1;
               set_wl_s   = 1'b1;
               cnt_next_s = '0;
            end else if (accept_s) begin
               wr_w_s     = 1'b1;
               cnt_next_s = cnt_r + CW'(1'b1);
            end else begin
               cnt_next_s = cnt_r;
            end
         end
         ST_LOAD_X: begin
            if (accept_s && (cnt_r == X_LAST)) begin
               wr_x_s     = 1'b1;
               cnt_next_s = '0;
            end else if (accept_s) begin
               wr_x_s     = 1'b1;
               cnt_next_s = cnt_r + CW'(1'b1);
            end else begin
               cnt_next_s = cnt_r;
            end
         end
         default: cnt_next_s = '0;
      endcase
   end

   // Bank storage, beat counter and sticky status flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N*N; i++) begin
            w_bank_r[i] <= '0;
         end
         for (int i = 0; i < N; i++) begin
            x_bank_r[i] <= '0;
         end
         cnt_r      <= '0;
         w_loaded_r <= 1'b0;
         err_no_w_r <= 1'b0;
      end else begin
         cnt_r <= cnt_next_s;
         if (wr_w_s) begin
            w_bank_r[cnt_r] <= in_data;
         end
         if (wr_x_s) begin
            x_bank_r[cnt_r[XW-1:0]] <= in_data;
         end
         if (set_wl_s) begin
            w_loaded_r <= 1'b1;
            err_no_w_r <= 1'b0;
         end else if (set_err_s) begin
            err_no_w_r <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < N*N; g++) begin : g_wflat
      assign w_flat[g*WIDTH +: WIDTH] = w_bank_r[g];
   end
   for (genvar g = 0; g < N; g++) begin : g_xflat
      assign x_flat[g*WIDTH +: WIDTH] = x_bank_r[g];
   end

   assign in_ready = in_ready_r;
   assign busy     = busy_r;
   assign start    = start_r;
   assign w_loaded = w_loaded_r;
   assign err_no_w = err_no_w_r;

   maxnet_input_loader_checker #(.WIDTH(WIDTH), .N(N)) u_checker (
      .clk      (clk),
      .rst      (rst),
      .in_ready (in_ready_r),
      .busy     (busy_r),
      .start    (start_r),
      .w_loaded (w_loaded_r),
      .err_no_w (err_no_w_r),
      .x_flat   (x_flat),
      .w_flat   (w_flat)
   );
endmodule

// Invariants of the loader handshake and bank stability.
module maxnet_input_loader_checker #(
   parameter int WIDTH = 32,
   parameter int N     = 4
) (
   input logic                 clk,
   input logic                 rst,
   input logic                 in_ready,
   input logic                 busy,
   input logic                 start,
   input logic                 w_loaded,
   input logic                 err_no_w,
   input logic [N*WIDTH-1:0]   x_flat,
   input logic [N*N*WIDTH-1:0] w_flat
);
   a_ready_busy_exclusive: assert property (@(posedge clk) disable iff (!rst)
      in_ready != busy);
   a_start_implies_busy: assert property (@(posedge clk) disable iff (!rst)
      start |-> busy);
   a_start_single_cycle: assert property (@(posedge clk) disable iff (!rst)
      start |=> !start);
   a_err_only_without_w: assert property (@(posedge clk) disable iff (!rst)
      !(err_no_w && w_loaded));
   // Banks must not move while the datapath is consuming them
   a_banks_stable: assert property (@(posedge clk) disable iff (!rst)
      (busy && $past(busy)) |-> (x_flat == $past(x_flat) && w_flat == $past(w_flat)));
endmodule
